// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
package intc_pkg;

  // Acknowledge handshake phases.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_ACK2
  } ack_state_e;

  // Number of bits needed to index n interrupt levels.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Level reported when an acknowledge finds no winning request.
  function automatic int spurious_level(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/prio_resolver.sv
// Combinational priority resolver: walks the levels from highest to lowest
// priority (starting just above the pointer) and picks the first pending
// request, unless an in-service level of equal or higher priority is met first.
module prio_resolver
  import intc_pkg::*;
#(
  parameter int N_IRQ = 8,
  localparam int IDX_W = idx_width(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [N_IRQ-1:0] isr,
  input  logic [IDX_W-1:0] ptr,
  output logic             win_valid,
  output logic [IDX_W-1:0] win_idx
);

  int               lvl;
  logic [IDX_W-1:0] lvl_idx;
  logic             done;

  // Scan levels in priority order; an in-service bit blocks everything below it.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    done      = 1'b0;
    lvl       = 0;
    lvl_idx   = '0;
    for (int r = 0; r < N_IRQ; r++) begin
      lvl = int'(ptr) + 1 + r;
      if (lvl >= N_IRQ) lvl = lvl - N_IRQ;
      lvl_idx = IDX_W'(lvl);
      if (!done) begin
        if (isr[lvl_idx]) begin
          done = 1'b1;
        end else if (req[lvl_idx]) begin
          win_valid = 1'b1;
          win_idx   = lvl_idx;
          done      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT for the highest-priority
// eligible request, runs the two-pulse INTA handshake, maintains the
// in-service register and presents the vector during the second INTA phase.
module int_ack_sequencer
  import intc_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8,
  localparam int IDX_W = idx_width(N_IRQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IRQ-1:0]       IRR,
  input  logic [N_IRQ-1:0]       IMR,
  input  logic                   INTA,
  input  logic                   auto_eoi,
  input  logic                   rotate,
  input  logic                   eoi,
  input  logic                   eoi_specific,
  input  logic [IDX_W-1:0]       eoi_level,
  input  logic [VEC_W-IDX_W-1:0] vec_base,
  output logic                   INT,
  output logic [N_IRQ-1:0]       irr_clr,
  output logic [N_IRQ-1:0]       ISR,
  output logic [VEC_W-1:0]       vector_address,
  output logic                   vec_valid
);

  localparam logic [IDX_W-1:0] SPUR_IDX = IDX_W'(spurious_level(N_IRQ));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IRQ - 1);
  localparam logic [N_IRQ-1:0] ONE      = N_IRQ'(1);

  ack_state_e       state_q, state_d;
  logic             inta_q, inta_q2;
  logic             inta_fall, inta_rise;
  logic [IDX_W-1:0] ptr_q, ptr_d, eff_ptr;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             spurious_q, spurious_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] set_mask, clr_mask;
  logic [N_IRQ-1:0] irr_clr_q;
  logic [VEC_W-1:0] vec_addr_q;
  logic             int_q, vec_valid_q;
  logic             win_valid, isr_any;
  logic [IDX_W-1:0] win_idx, isr_top_idx;
  logic             ack_take, vec_load, ack_done;

  assign inta_fall = inta_q2 & ~inta_q;
  assign inta_rise = ~inta_q2 & inta_q;
  assign eff_ptr   = rotate ? ptr_q : LAST_IDX;

  prio_resolver #(.N_IRQ(N_IRQ)) u_win (
    .req       (IRR & ~IMR),
    .isr       (isr_q),
    .ptr       (eff_ptr),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  prio_resolver #(.N_IRQ(N_IRQ)) u_top_isr (
    .req       (isr_q),
    .isr       ({N_IRQ{1'b0}}),
    .ptr       (eff_ptr),
    .win_valid (isr_any),
    .win_idx   (isr_top_idx)
  );

  // State register plus the INTA synchroniser used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      inta_q  <= 1'b1;
      inta_q2 <= 1'b1;
    end else begin
      state_q <= state_d;
      inta_q  <= INTA;
      inta_q2 <= inta_q;
    end
  end

  // Handshake sequencing; INTA edges outside a request are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_valid) state_d = ST_REQ;
      ST_REQ:  if (inta_fall) state_d = ST_ACK1;
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: if (inta_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Derive ISR set/clear masks, latched index and rotation pointer updates.
  always_comb begin
    ack_take   = (state_q == ST_REQ) && inta_fall;
    vec_load   = (state_q == ST_ACK1) && inta_fall;
    ack_done   = (state_q == ST_ACK2) && inta_rise;
    set_mask   = '0;
    clr_mask   = '0;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    spurious_d = spurious_q;
    if (ack_take) begin
      spurious_d = !win_valid;
      idx_d      = win_valid ? win_idx : SPUR_IDX;
      if (win_valid) set_mask = ONE << win_idx;
    end
    if (ack_done && auto_eoi && !spurious_q) begin
      clr_mask = clr_mask | (ONE << idx_q);
      if (rotate) ptr_d = idx_q;
    end
    if (eoi) begin
      if (eoi_specific) begin
        if (isr_q[eoi_level]) begin
          clr_mask = clr_mask | (ONE << eoi_level);
          if (rotate) ptr_d = eoi_level;
        end
      end else if (isr_any) begin
        clr_mask = clr_mask | (ONE << isr_top_idx);
        if (rotate) ptr_d = isr_top_idx;
      end
    end
    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_q       <= '0;
      ptr_q       <= LAST_IDX;
      idx_q       <= '0;
      spurious_q  <= 1'b0;
      irr_clr_q   <= '0;
      int_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_addr_q  <= '0;
    end else begin
      isr_q       <= isr_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      spurious_q  <= spurious_d;
      irr_clr_q   <= set_mask;
      int_q       <= (state_d == ST_REQ);
      vec_valid_q <= (state_d == ST_ACK2);
      if (vec_load) vec_addr_q <= {vec_base, idx_q};
    end
  end

  assign INT            = int_q;
  assign irr_clr        = irr_clr_q;
  assign ISR            = isr_q;
  assign vector_address = vec_addr_q;
  assign vec_valid      = vec_valid_q;

endmodule

// File: doc/int_ack_sequencer.md
INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

Interface
REQ-001 Parameter N_IRQ, 8, number of interrupt request levels (2..32).
REQ-002 Parameter VEC_W, 8, vector bus width; SHALL be >= IDX_W+1, where IDX_W = clog2(N_IRQ).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port IRR  input  N_IRQ  pending requests, held by the external request register.
REQ-006 Port IMR  input  N_IRQ  mask; 1 = level masked.
REQ-007 Port INTA  input  1  CPU acknowledge, active-low, already synchronous to clk.
REQ-008 Port auto_eoi  input  1  1 = ISR bit cleared at the end of the acknowledge cycle.
REQ-009 Port rotate  input  1  1 = rotating priority, 0 = fixed priority (level 0 highest).
REQ-010 Port eoi  input  1  one-cycle end-of-interrupt strobe.
REQ-011 Port eoi_specific  input  1  qualifies eoi; 1 = clear level eoi_level, 0 = clear the highest-priority ISR bit.
REQ-012 Port eoi_level  input  IDX_W  level for a specific EOI.
REQ-013 Port vec_base  input  VEC_W-IDX_W  upper vector bits.
REQ-014 Port INT  output  1  interrupt request to the CPU, active-high, registered.
REQ-015 Port irr_clr  output  N_IRQ  one-hot, one-cycle pulse that clears the acknowledged IRR bit.
REQ-016 Port ISR  output  N_IRQ  in-service register.
REQ-017 Port vector_address  output  VEC_W  {vec_base, idx}; valid while vec_valid = 1.
REQ-018 Port vec_valid  output  1  1 during the second INTA low phase.

Function
REQ-019 Acknowledge edge: INTA is registered once; an edge is the prev=1, now=0 transition, detected one cycle after INTA falls.
REQ-020 Eligible set: IRR & ~IMR; a candidate wins only if its priority is strictly higher than every set ISR bit.
REQ-021 FSM states: IDLE, REQ, ACK1, ACK2.
REQ-022 IDLE -> REQ when any candidate wins; INT = 1 from the next cycle.
REQ-023 REQ -> ACK1 on the first INTA edge:
- latch the winner index;
- set the ISR bit;
- pulse irr_clr for 1 cycle;
- INT = 0 from the next cycle.
REQ-024 Spurious acknowledge: if no candidate exists at the first edge, latch idx = N_IRQ-1, leave ISR and irr_clr unchanged, and set a spurious flag.
REQ-025 ACK1 -> ACK2 on the second INTA edge:
- vector_address = {vec_base, idx};
- vec_valid = 1 until INTA is registered high.
REQ-026 ACK2 -> IDLE on the registered rising edge of INTA:
- vec_valid = 0;
- if auto_eoi = 1 and the cycle was not spurious, clear the ISR bit of idx (with rotation applied when rotate = 1).
REQ-027 Rotating priority: a 3-bit-wide (IDX_W) pointer names the lowest-priority level; on each EOI that clears level k with rotate = 1, the pointer becomes k. Priority order is pointer+1, pointer+2, ..., wrapping modulo N_IRQ.
REQ-028 Non-specific EOI with ISR = 0 is a no-op; specific EOI on a clear bit is a no-op.
REQ-029 An EOI in the same cycle as an ISR set applies both; the clear targets only the previously set bits.
REQ-030 INTA edges in IDLE are ignored: no state change, vec_valid stays 0.
REQ-031 IRR or IMR changes while in REQ do not deassert INT; the winner is re-evaluated at the first edge (see REQ-024).
REQ-032 Nesting: a higher-priority request may start a new sequence while lower ISR bits remain set.

Reset
REQ-033 While rst_n = 0:
- state = IDLE, INT = 0;
- ISR = 0, irr_clr = 0;
- vector_address = 0, vec_valid = 0;
- priority pointer = N_IRQ-1 (level 0 highest), spurious flag = 0.
REQ-034 Reset asserted mid-sequence aborts the sequence immediately; the first cycle after reset release evaluates from IDLE.

Structure
REQ-035 Package intc_pkg SHALL hold the FSM state enum, the IDX_W clog2 function and the spurious-level constant.
REQ-036 Sub-module prio_resolver SHALL be combinational. Inputs: request vector, ISR, pointer. Outputs: win valid and win index.

Verification
REQ-037 Fixed priority: IRR = 0x24, IMR = 0 -> INT = 1. After 2 INTA pulses: vector_address = {vec_base, 2}, ISR = 0x04, irr_clr = 0x04.
REQ-038 Masking/nesting: ISR = 0x10, IRR = 0x40 -> INT stays 0. Then IRR = 0x01 -> INT = 1 and the sequence yields ISR = 0x11.
REQ-039 Spurious: IRR = 0x08 drops to 0 before the first INTA -> vector index 7, ISR unchanged, irr_clr = 0.
REQ-040 Rotation: rotate = 1, serve level 3, then non-specific EOI -> pointer = 3. Simultaneous IRR = 0x09 -> level 0 loses to level 3? No: level 3 is lowest, so level 0 wins.
REQ-041 Auto-EOI: auto_eoi = 1, IRR = 0x02 -> after the INTA rising edge ISR = 0x00; no eoi strobe needed.
REQ-042 Reset mid-ACK1: rst_n pulsed low -> INT = 0, ISR = 0, vec_valid = 0; a subsequent INTA edge is ignored.
